// File: rtl/smt_fetch_unit.sv
// Round-robin instruction fetch initiator for a multi-threaded instruction memory.
// Keeps one slot counter per thread and registers fetched words into a valid/ready stage.
module smt_fetch_unit #(
  parameter int unsigned NUM_THREADS      = 5,
  parameter int unsigned SLOTS_PER_THREAD = 100,
  parameter int unsigned ADDR_W           = 9,
  parameter int unsigned DATA_W           = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] thread_en_i,
  output logic [ADDR_W-1:0]      imem_addr_o,
  input  logic [DATA_W-1:0]      imem_rd_i,
  output logic [DATA_W-1:0]      instr_o,
  output logic [2:0]             tid_o,
  output logic [6:0]             slot_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  input  logic                   redirect_valid_i,
  input  logic [2:0]             redirect_tid_i,
  input  logic [6:0]             redirect_slot_i,
  output logic                   err_o
);

  logic [6:0]        pc_q [NUM_THREADS];
  logic [2:0]        rr_q;
  logic [DATA_W-1:0] instr_q;
  logic [2:0]        tid_q;
  logic [6:0]        slot_q;
  logic              valid_q;
  logic              err_q;

  logic       found;
  logic [2:0] sel;
  logic [2:0] rr_next;
  logic [6:0] pc_sel;
  logic [6:0] pc_inc;
  logic       any_en;
  logic       advance;
  logic       redirect_ok;
  logic       fetch;
  logic       squash;

  // First enabled thread at or after rr_q; falls back to rr_q when none is enabled.
  always_comb begin
    sel   = rr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % NUM_THREADS;
      if (!found && thread_en_i[idx]) begin
        sel   = 3'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_en      = |thread_en_i;
  assign pc_sel      = pc_q[sel];
  assign pc_inc      = (32'(pc_sel) == SLOTS_PER_THREAD - 1) ? 7'd0 : pc_sel + 7'd1;
  assign rr_next     = (32'(sel) == NUM_THREADS - 1) ? 3'd0 : sel + 3'd1;
  assign imem_addr_o = ADDR_W'(32'(sel) * SLOTS_PER_THREAD + 32'(pc_sel));

  assign advance     = !valid_q || ready_i;
  assign redirect_ok = redirect_valid_i && (32'(redirect_tid_i) < NUM_THREADS) &&
                       (32'(redirect_slot_i) < SLOTS_PER_THREAD);
  // A redirect hitting the selected thread suppresses its fetch so the new slot is used next.
  assign fetch       = advance && any_en && !(redirect_ok && redirect_tid_i == sel);
  assign squash      = redirect_ok && valid_q && !ready_i && tid_q == redirect_tid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= '0;
      end
      rr_q    <= '0;
      instr_q <= '0;
      tid_q   <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (redirect_valid_i && !redirect_ok) begin
        err_q <= 1'b1;
      end
      if (fetch) begin
        instr_q  <= imem_rd_i;
        tid_q    <= sel;
        slot_q   <= pc_sel;
        valid_q  <= 1'b1;
        pc_q[sel] <= pc_inc;
        rr_q     <= rr_next;
      end else if (advance || squash) begin
        valid_q <= 1'b0;
      end
      if (redirect_ok) begin
        pc_q[redirect_tid_i] <= redirect_slot_i;
      end
    end
  end

  assign instr_o = instr_q;
  assign tid_o   = tid_q;
  assign slot_o  = slot_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_smt_fetch_unit.sv
// Directed plus randomized checks of smt_fetch_unit against a thread/slot reference model.
module tb_smt_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  thread_en_i;
  logic [8:0]  imem_addr_o;
  logic [31:0] imem_rd_i;
  logic [31:0] instr_o;
  logic [2:0]  tid_o;
  logic [6:0]  slot_o;
  logic        valid_o;
  logic        ready_i;
  logic        redirect_valid_i;
  logic [2:0]  redirect_tid_i;
  logic [6:0]  redirect_slot_i;
  logic        err_o;

  logic [31:0] mem [512];

  always #5 clk = ~clk;
  assign imem_rd_i = mem[imem_addr_o];

  smt_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .thread_en_i      (thread_en_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rd_i        (imem_rd_i),
    .instr_o          (instr_o),
    .tid_o            (tid_o),
    .slot_o           (slot_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_tid_i   (redirect_tid_i),
    .redirect_slot_i  (redirect_slot_i),
    .err_o            (err_o)
  );

  int errors = 0;
  int checks = 0;
  int want_addr = -1;

  // Reference model: thread program counters and the expected output stage.
  int          m_pc [5];
  int          m_rr;
  logic [31:0] m_instr;
  int          m_tid;
  int          m_slot;
  logic        m_valid;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 5; t++) m_pc[t] = 0;
    m_rr = 0; m_instr = '0; m_tid = 0; m_slot = 0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  // One clock: check the combinational address, advance the model, check registered outputs.
  task automatic step();
    int  sel, addr, rtid, rslot;
    bit  rok, adv, fetch;
    #3;
    sel = m_rr;
    for (int k = 4; k >= 0; k--) begin
      if (thread_en_i[(m_rr + k) % 5]) sel = (m_rr + k) % 5;
    end
    addr = sel * 100 + m_pc[sel];
    check("imem_addr", 32'(imem_addr_o), 32'(addr));
    if (want_addr >= 0) check("directed_addr", 32'(imem_addr_o), 32'(want_addr));
    want_addr = -1;
    if (rst) begin
      model_reset();
    end else begin
      rtid  = int'(redirect_tid_i);
      rslot = int'(redirect_slot_i);
      rok   = redirect_valid_i && rtid < 5 && rslot < 100;
      adv   = !m_valid || ready_i;
      fetch = adv && (thread_en_i != 0) && !(rok && rtid == sel);
      if (redirect_valid_i && !rok) m_err = 1'b1;
      if (fetch) begin
        m_instr = mem[addr];
        m_tid   = sel;
        m_slot  = m_pc[sel];
        m_valid = 1'b1;
        m_pc[sel] = (m_pc[sel] + 1) % 100;
        m_rr    = (sel + 1) % 5;
      end else if (adv) begin
        m_valid = 1'b0;
      end else if (rok && m_tid == rtid) begin
        m_valid = 1'b0;
      end
      if (rok) m_pc[rtid] = rslot;
    end
    @(posedge clk);
    #1;
    check("valid", 32'(valid_o), 32'(m_valid));
    check("instr", instr_o, m_instr);
    check("tid", 32'(tid_o), 32'(m_tid));
    check("slot", 32'(slot_o), 32'(m_slot));
    check("err", 32'(err_o), 32'(m_err));
  endtask

  task automatic set_redirect(input logic v, input int tid, input int slot);
    redirect_valid_i = v;
    redirect_tid_i   = 3'(tid);
    redirect_slot_i  = 7'(slot);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    model_reset();
    rst = 1'b1; thread_en_i = '0; ready_i = 1'b1;
    set_redirect(1'b0, 0, 0);
    @(posedge clk); #1;
    step();
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_instr", instr_o, 32'd0);
    rst = 1'b0;

    // All threads enabled: addresses walk thread bases, then the next slot of each.
    thread_en_i = 5'b11111;
    for (int i = 0; i < 12; i++) begin
      want_addr = (i % 5) * 100 + i / 5;
      step();
    end

    // Slot wrap on thread 2.
    thread_en_i = 5'b00100;
    set_redirect(1'b1, 2, 99);
    step();
    set_redirect(1'b0, 0, 0);
    want_addr = 299;
    step();
    check("wrap_slot99", 32'(slot_o), 32'd99);
    want_addr = 200;
    step();
    check("wrap_slot0", 32'(slot_o), 32'd0);

    // Backpressure for three cycles, then resume.
    thread_en_i = 5'b11111;
    step();
    ready_i = 1'b0;
    repeat (3) step();
    ready_i = 1'b1;
    repeat (4) step();

    // Redirect colliding with a stalled thread-1 instruction.
    thread_en_i = 5'b00010;
    step();
    ready_i = 1'b0;
    set_redirect(1'b1, 1, 40);
    step();
    check("squash_valid", 32'(valid_o), 32'd0);
    ready_i = 1'b1;
    set_redirect(1'b0, 0, 0);
    want_addr = 140;
    step();
    check("collision_slot", 32'(slot_o), 32'd40);

    // Illegal redirects leave pcs untouched and set the sticky error.
    thread_en_i = 5'b11111;
    set_redirect(1'b1, 6, 5);
    step();
    check("err_set", 32'(err_o), 32'd1);
    set_redirect(1'b1, 1, 100);
    step();
    set_redirect(1'b0, 0, 0);
    repeat (5) step();

    // Masked threads, then everything disabled.
    thread_en_i = 5'b01010;
    repeat (6) step();
    thread_en_i = 5'b00000;
    repeat (2) step();
    check("idle_valid", 32'(valid_o), 32'd0);

    // Randomized traffic including illegal redirects.
    for (int i = 0; i < 400; i++) begin
      thread_en_i = 5'($urandom);
      ready_i     = ($urandom % 4) != 0;
      set_redirect(($urandom % 6) == 0,
                   ($urandom % 10 == 0) ? 5 + int'($urandom % 3) : int'($urandom % 5),
                   ($urandom % 10 == 0) ? 100 + int'($urandom % 28) : int'($urandom % 100));
      step();
    end

    // Mid-stream reset with a redirect pending.
    thread_en_i = 5'b11111;
    ready_i = 1'b0;
    rst = 1'b1;
    set_redirect(1'b1, 3, 7);
    step();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst = 1'b0;
    ready_i = 1'b1;
    set_redirect(1'b0, 0, 0);
    want_addr = 0;
    step();
    want_addr = 100;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
